// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble controls plus forwarding selects.
// Latency: stage controls and forwards are combinational; md_busy/stall_cycles come from registers.
// Backpressure: a stall holds PC and IF/ID and injects a bubble into ID/EX; a taken jump flushes IF/ID only when unstalled.
//
// Ports:
//   clk, rst_n                           core clock, async active-low reset
//   id_*                                 sources/flags of the instruction in ID
//   ex_*, mem_*, wb_*                    producer info of the EX/MEM/WB instructions
//   pc_en, ifid_en, ifid_clr, idex_clr   stage register enables and clears
//   fwd_id_a/b                           ID branch comparator takes the MEM result
//   fwd_ex_a/b                           ALU operand source: 00 regfile, 01 MEM, 10 WB
//   md_busy, stall_cycles                MDU busy flag and saturating stall counter
module hazard_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_read,
  input  logic        id_rt_read,
  input  logic        id_branch,
  input  logic        id_md,
  input  logic        id_jump_taken,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic        ex_md_start,
  input  logic        ex_md_div,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic        mem_memread,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_clr,
  output logic        idex_clr,
  output logic        fwd_id_a,
  output logic        fwd_id_b,
  output logic [1:0]  fwd_ex_a,
  output logic [1:0]  fwd_ex_b,
  output logic        md_busy,
  output logic [31:0] stall_cycles
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

  localparam logic [1:0] SRC_RF  = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_WB  = 2'b10;

  // A producer feeds a consumer only if it really writes, the destination is
  // not $0, the numbers agree and the consumer actually reads that operand.
  function automatic logic hit(input logic       wr,
                               input logic [4:0] dst,
                               input logic [4:0] src,
                               input logic       rd);
    return wr && (dst != 5'd0) && (dst == src) && rd;
  endfunction

  logic [3:0] md_cnt;

  logic ex_hit_rs, ex_hit_rt;
  logic mem_hit_rs, mem_hit_rt;
  logic load_use_stall;
  logic branch_stall;
  logic md_stall;
  logic stall;

  always_comb begin
    ex_hit_rs  = hit(ex_regwrite, ex_rd, id_rs, id_rs_read);
    ex_hit_rt  = hit(ex_regwrite, ex_rd, id_rt, id_rt_read);
    mem_hit_rs = hit(mem_regwrite, mem_rd, id_rs, id_rs_read);
    mem_hit_rt = hit(mem_regwrite, mem_rd, id_rt, id_rt_read);

    load_use_stall = ex_memread && (ex_hit_rs || ex_hit_rt);

    // The ID comparator can only take a forward from MEM, and only for a
    // non-load; anything in EX, or a load in MEM, is not ready yet.
    branch_stall = id_branch &&
                   ((ex_hit_rs || ex_hit_rt) ||
                    (mem_memread && (mem_hit_rs || mem_hit_rt)));

    // The start cycle itself also counts as busy: the MDU result is not
    // available until the counter has drained.
    md_stall = id_md && (md_busy || ex_md_start);

    stall = load_use_stall || branch_stall || md_stall;
  end

  // Stage controls. A stalled jump must not flush IF/ID, otherwise the
  // instruction being held there would be lost; the flush happens later in
  // the cycle the jump finally resolves unstalled.
  always_comb begin
    pc_en    = ~stall;
    ifid_en  = ~stall;
    idex_clr = stall;
    ifid_clr = ~stall & id_jump_taken;
  end

  // Forwarding selects.
  always_comb begin
    fwd_id_a = ~mem_memread & mem_hit_rs;
    fwd_id_b = ~mem_memread & mem_hit_rt;

    fwd_ex_a = SRC_RF;
    if (hit(mem_regwrite, mem_rd, ex_rs, 1'b1))
      fwd_ex_a = SRC_MEM;
    else if (hit(wb_regwrite, wb_rd, ex_rs, 1'b1))
      fwd_ex_a = SRC_WB;

    fwd_ex_b = SRC_RF;
    if (hit(mem_regwrite, mem_rd, ex_rt, 1'b1))
      fwd_ex_b = SRC_MEM;
    else if (hit(wb_regwrite, wb_rd, ex_rt, 1'b1))
      fwd_ex_b = SRC_WB;
  end

  // MDU occupancy counter. A start while the counter is running is ignored;
  // the MDU stall keeps a second mult/div out of EX in that window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= 4'd0;
    end else if (ex_md_start && (md_cnt == 4'd0)) begin
      md_cnt <= ex_md_div ? DIV_LD : MULT_LD;
    end else if (md_cnt != 4'd0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

  // Derived straight from the counter flop so an async reset drops it at once.
  assign md_busy = (md_cnt != 4'd0);

  // Stall performance counter, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic        id_rs_read, id_rt_read, id_branch, id_md, id_jump_taken;
  logic        ex_regwrite, ex_memread, ex_md_start, ex_md_div;
  logic        mem_regwrite, mem_memread, wb_regwrite;
  logic        pc_en, ifid_en, ifid_clr, idex_clr, fwd_id_a, fwd_id_b, md_busy;
  logic [1:0]  fwd_ex_a, fwd_ex_b;
  logic [31:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_read(id_rs_read), .id_rt_read(id_rt_read),
    .id_branch(id_branch), .id_md(id_md), .id_jump_taken(id_jump_taken),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b),
    .md_busy(md_busy), .stall_cycles(stall_cycles)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: a cycle index, the window of cycles in which the
  // MDU is busy, and the number of stalled cycles so far.
  int     cyc     = 0;
  int     busy_lo = 1;
  int     busy_hi = 0;
  longint m_stalls = 0;

  // Last observed outputs, for directed constant checks.
  logic o_pc_en, o_ifid_en, o_ifid_clr, o_idex_clr, o_fwd_id_a, o_md_busy;
  logic [1:0] o_fwd_ex_a, o_fwd_ex_b;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit feeds(input bit wr, input logic [4:0] dst,
                               input logic [4:0] src, input bit reads);
    return wr && (dst != 0) && (dst == src) && reads;
  endfunction

  function automatic bit m_busy();
    return (cyc >= busy_lo) && (cyc <= busy_hi);
  endfunction

  function automatic bit m_stall();
    bit ex_rs_m, ex_rt_m, mem_rs_m, mem_rt_m;
    ex_rs_m  = feeds(ex_regwrite, ex_rd, id_rs, id_rs_read);
    ex_rt_m  = feeds(ex_regwrite, ex_rd, id_rt, id_rt_read);
    mem_rs_m = feeds(mem_regwrite, mem_rd, id_rs, id_rs_read);
    mem_rt_m = feeds(mem_regwrite, mem_rd, id_rt, id_rt_read);
    if (ex_memread && (ex_rs_m || ex_rt_m)) return 1;
    if (id_branch && (ex_rs_m || ex_rt_m)) return 1;
    if (id_branch && mem_memread && (mem_rs_m || mem_rt_m)) return 1;
    if (id_md && (m_busy() || ex_md_start)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] m_fwd_ex(input logic [4:0] src);
    if (feeds(mem_regwrite, mem_rd, src, 1)) return 2'd1;
    if (feeds(wb_regwrite, wb_rd, src, 1)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_all(input string tag);
    bit s;
    longint sat;
    s   = m_stall();
    sat = (m_stalls > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stalls;
    cmp({tag, ".pc_en"},    pc_en,    !s);
    cmp({tag, ".ifid_en"},  ifid_en,  !s);
    cmp({tag, ".idex_clr"}, idex_clr, s);
    cmp({tag, ".ifid_clr"}, ifid_clr, !s && id_jump_taken);
    cmp({tag, ".fwd_id_a"}, fwd_id_a, !mem_memread && feeds(mem_regwrite, mem_rd, id_rs, id_rs_read));
    cmp({tag, ".fwd_id_b"}, fwd_id_b, !mem_memread && feeds(mem_regwrite, mem_rd, id_rt, id_rt_read));
    cmp({tag, ".fwd_ex_a"}, fwd_ex_a, m_fwd_ex(ex_rs));
    cmp({tag, ".fwd_ex_b"}, fwd_ex_b, m_fwd_ex(ex_rt));
    cmp({tag, ".md_busy"},  md_busy,  m_busy());
    cmp({tag, ".stall_cycles"}, stall_cycles, sat[31:0]);
    o_pc_en = pc_en; o_ifid_en = ifid_en; o_ifid_clr = ifid_clr; o_idex_clr = idex_clr;
    o_fwd_id_a = fwd_id_a; o_md_busy = md_busy; o_fwd_ex_a = fwd_ex_a; o_fwd_ex_b = fwd_ex_b;
  endtask

  // Called at the rising edge, before inputs change.
  task automatic model_update();
    if (m_stall()) m_stalls++;
    if (ex_md_start && !m_busy()) begin
      busy_lo = cyc + 1;
      busy_hi = cyc + (ex_md_div ? DIV_N : MULT_N);
    end
    cyc++;
  endtask

  // Inputs are set just after a rising edge; outputs are checked mid-cycle.
  task automatic cycle(input string tag);
    #2;
    check_all(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_rs_read = 0; id_rt_read = 0; id_branch = 0; id_md = 0;
    id_jump_taken = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    ex_md_start = 0; ex_md_div = 0; mem_rd = 0; mem_regwrite = 0; mem_memread = 0;
    wb_rd = 0; wb_regwrite = 0;
  endtask

  initial begin
    int base, n_st, n_busy;
    idle();
    rst_n = 0;

    // Reset state with all inputs low.
    #3;
    cmp("rst.pc_en", pc_en, 1); cmp("rst.ifid_en", ifid_en, 1);
    cmp("rst.ifid_clr", ifid_clr, 0); cmp("rst.idex_clr", idex_clr, 0);
    cmp("rst.fwd_ex_a", fwd_ex_a, 0); cmp("rst.md_busy", md_busy, 0);
    cmp("rst.stall_cycles", stall_cycles, 0);
    @(posedge clk); #1;
    rst_n = 1;
    cycle("idle");

    // Load-use: lw $3 in EX, add reading $3 in ID.
    ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_rs = 3; id_rs_read = 1;
    cycle("lu0");
    cmp("lu.pc_en", o_pc_en, 0); cmp("lu.ifid_en", o_ifid_en, 0); cmp("lu.idex_clr", o_idex_clr, 1);
    idle(); mem_memread = 1; mem_regwrite = 1; mem_rd = 3; id_rs = 3; id_rs_read = 1;
    cycle("lu1");
    cmp("lu.free", o_pc_en, 1); cmp("lu.count", stall_cycles, 1);

    // Load into $0 never stalls.
    idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 0; id_rs = 0; id_rs_read = 1;
    cycle("lu_r0");
    cmp("lu_r0.pc_en", o_pc_en, 1);

    // lw $5 then beq on $5: EX match, then MEM load match, then free.
    base = stall_cycles;
    idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_branch = 1; id_rs = 5; id_rs_read = 1;
    cycle("br0");
    idle(); mem_memread = 1; mem_regwrite = 1; mem_rd = 5; id_branch = 1; id_rs = 5; id_rs_read = 1;
    cycle("br1");
    cmp("br1.pc_en", o_pc_en, 0);
    idle(); wb_regwrite = 1; wb_rd = 5; id_branch = 1; id_rs = 5; id_rs_read = 1; ex_rs = 5;
    cycle("br2");
    cmp("br2.pc_en", o_pc_en, 1); cmp("br2.fwd_id_a", o_fwd_id_a, 0); cmp("br2.fwd_ex_a", o_fwd_ex_a, 2);
    cmp("br.count", stall_cycles - base, 2);

    // EX forwarding priority and $0 suppression.
    idle(); mem_regwrite = 1; mem_rd = 7; wb_regwrite = 1; wb_rd = 7; ex_rs = 7; ex_rt = 7;
    cycle("fx_mem");
    cmp("fx.mem_a", o_fwd_ex_a, 1); cmp("fx.mem_b", o_fwd_ex_b, 1);
    mem_regwrite = 0;
    cycle("fx_wb");
    cmp("fx.wb_a", o_fwd_ex_a, 2); cmp("fx.wb_b", o_fwd_ex_b, 2);
    mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    cycle("fx_r0");
    cmp("fx.r0_a", o_fwd_ex_a, 0); cmp("fx.r0_b", o_fwd_ex_b, 0);

    // Divide start then mflo in ID: held for the start cycle plus every busy cycle.
    idle(); ex_md_start = 1; ex_md_div = 1; id_md = 1;
    n_st = 0; n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      cycle("mdu");
      if (o_md_busy) n_busy++;
      if (o_pc_en) break;
      n_st++;
      ex_md_start = 0; ex_md_div = 0;
    end
    cmp("mdu.stalls", n_st, DIV_N + 1);
    cmp("mdu.busy", n_busy, DIV_N);

    // Taken jump: flush when free, withheld while a branch stall holds it.
    idle(); id_jump_taken = 1;
    cycle("jmp_free");
    cmp("jmp.clr", o_ifid_clr, 1);
    idle(); id_jump_taken = 1; id_branch = 1; id_rs = 4; id_rs_read = 1; ex_regwrite = 1; ex_rd = 4;
    cycle("jmp_stall");
    cmp("jmp.stall_clr", o_ifid_clr, 0);
    idle(); id_jump_taken = 1; id_branch = 1; id_rs = 4; id_rs_read = 1; mem_regwrite = 1; mem_rd = 4;
    cycle("jmp_res");
    cmp("jmp.res_clr", o_ifid_clr, 1); cmp("jmp.res_fwd", o_fwd_id_a, 1);

    // Randomized traffic over a small register set to provoke matches.
    for (int i = 0; i < 2000; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rs_read = 1'($urandom); id_rt_read = 1'($urandom);
      id_branch = ($urandom_range(0, 3) == 0); id_md = ($urandom_range(0, 3) == 0);
      id_jump_taken = ($urandom_range(0, 3) == 0);
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3)); ex_regwrite = 1'($urandom); ex_memread = 1'($urandom);
      ex_md_start = ($urandom_range(0, 7) == 0); ex_md_div = 1'($urandom);
      mem_rd = 5'($urandom_range(0, 3)); mem_regwrite = 1'($urandom); mem_memread = 1'($urandom);
      wb_rd = 5'($urandom_range(0, 3)); wb_regwrite = 1'($urandom);
      cycle("rnd");
    end

    // Reset in the middle of a multiply, between clock edges.
    idle();
    for (int i = 0; i < 12; i++) cycle("drain");
    id_md = 1; ex_md_start = 1;
    cycle("mul0");
    idle();
    cycle("mul1");
    cmp("mul.busy", o_md_busy, 1);
    #2;
    rst_n = 0;
    #1;
    cmp("arst.md_busy", md_busy, 0);
    cmp("arst.stall_cycles", stall_cycles, 0);
    busy_lo = 1; busy_hi = 0; m_stalls = 0; cyc = 0;
    @(posedge clk); #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) cycle("post_rst");
    cmp("post_rst.busy", o_md_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. It produces the enable and clear controls for the stage registers: PC and IF/ID enables, the IF/ID flush and the ID/EX bubble. It also generates operand forwarding selects for the ID branch comparator and the EX ALU. It owns a multi-cycle multiply/divide busy counter and a stall-cycle performance counter.

## Interface
- MULT_CYC, 5: EX-stage cycles a multiply occupies the MDU.
- DIV_CYC, 10: EX-stage cycles a divide occupies the MDU.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
- id_rs_read, id_rt_read  in  1 each  ID instruction reads rs / rt.
- id_branch  in  1  ID instruction compares rs/rt in ID (beq/bne/jr).
- id_md  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- id_jump_taken  in  1  branch/jump in ID resolved taken.
- ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination of the EX instruction.
- ex_regwrite, ex_memread  in  1 each  EX instruction writes a GPR / is a load.
- ex_md_start, ex_md_div  in  1 each  EX instruction starts the MDU / the operation is a divide.
- mem_rd  in  5  destination of the MEM instruction.
- mem_regwrite, mem_memread  in  1 each  MEM instruction writes a GPR / is a load.
- wb_rd  in  5  destination of the WB instruction.
- wb_regwrite  in  1  WB instruction writes a GPR.
- pc_en, ifid_en  out  1 each  enables for the PC and IF/ID registers.
- ifid_clr, idex_clr  out  1 each  synchronous clears for IF/ID and ID/EX.
- fwd_id_a, fwd_id_b  out  1 each  branch comparator operand taken from the MEM result.
- fwd_ex_a, fwd_ex_b  out  2 each  ALU operand source: 00 register file, 01 MEM result, 10 WB result.
- md_busy  out  1  MDU counter nonzero.
- stall_cycles  out  32  count of stalled cycles since reset.

## Operation
- Match rule: a producer P matches source S only if P writes a GPR, P's destination is nonzero, and P's destination equals S, with S's read flag set where one exists.
- Load-use stall: the EX instruction is a load and it matches id_rs or id_rt.
- Branch stall: id_branch is set and either of the following holds:
  - any EX writer matches an ID source;
  - a MEM load matches an ID source.
- MDU stall: id_md is set and either md_busy or ex_md_start is 1.
- stall is the OR of the three stall conditions. When stall=1:
  - pc_en=0 and ifid_en=0;
  - idex_clr=1;
  - ifid_clr=0, so the held instruction is not lost.
- When stall=0: pc_en=1, ifid_en=1, idex_clr=0, ifid_clr=id_jump_taken.
- fwd_id_a/b: 1 when a non-load MEM instruction matches id_rs/id_rt; otherwise 0.
- fwd_ex_a/b:
  - 01 when a MEM writer matches ex_rs/ex_rt;
  - else 10 when a WB writer matches;
  - else 00.
  - MEM has priority over WB.
- MDU counter (4 bits):
  - When ex_md_start=1 and the count is 0, load DIV_CYC if ex_md_div=1, else MULT_CYC.
  - Otherwise, decrement while nonzero.
  - ex_md_start while the count is nonzero is ignored; the stall logic makes that case unreachable.
- stall_cycles: increments on every cycle where stall=1 and saturates at 32'hFFFF_FFFF.
- All outputs except md_busy and stall_cycles are combinational from the current inputs and counter state.

## Timing
- Reset (rst_n=0, asynchronous): MDU count=0, md_busy=0, stall_cycles=0.
  - Combinational outputs follow the inputs; with all inputs 0 they are pc_en=1, ifid_en=1, clears=0, forwards=0.
  - Reset during an MDU operation clears md_busy immediately, without waiting for a clock edge.
- Load-use stall: exactly one bubble. On the next edge the load moves to MEM and the condition clears unless a branch stall applies.
- Branch after a load: two stall cycles (EX match, then MEM match). Branch after an ALU op: one stall cycle, then fwd_id=1.
- MDU timing:
  - md_busy rises on the edge after the ex_md_start cycle and stays high for MULT_CYC or DIV_CYC cycles.
  - An id_md instruction is held through the start cycle plus every busy cycle, and issues in the first cycle where md_busy=0.
- Simultaneous stall and id_jump_taken: stall wins and ifid_clr=0. The flush occurs in the cycle the branch finally resolves unstalled.
- ex_rd=0, mem_rd=0 or wb_rd=0 never causes a stall or a forward.

## Test plan
- lw $3 in EX, ID add reading rs=3 -> one cycle with pc_en=0, ifid_en=0, idex_clr=1; next cycle all free and stall_cycles=1.
- lw $5 in EX followed by beq rs=5 -> stall for 2 cycles, then fwd_id_a=0 and fwd_ex_a=10 path checked; stall_cycles=2.
- MEM and WB both write $7, EX reads rs=7, rt=7 -> fwd_ex_a=01, fwd_ex_b=01. With MEM regwrite=0 -> both 10. With rd=0 -> both 00.
- ex_md_start with ex_md_div=1, then mflo in ID -> stall for 11 cycles (start cycle plus 10 busy), md_busy high 10 cycles, then mflo issues.
- id_jump_taken with no hazard -> ifid_clr=1 for one cycle. id_jump_taken with a branch stall active -> ifid_clr=0 until the stall clears.
- Start a mult, then assert rst_n=0 mid-count with no clock edge -> md_busy=0 and stall_cycles=0 immediately; after release the counter stays 0.
